// File: rtl/iomem_bridge_master_pkg.sv
// Shared constants and types for the byte-stream to iomem bridge.
//   - Command opcodes ('W', 'R') and response bytes ('K', '?', 'T')
//   - FSM state encoding
//   - iomem address / data width
package iomem_bridge_master_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;

    localparam logic [7:0] OpWrite = 8'h57;  // 'W'
    localparam logic [7:0] OpRead  = 8'h52;  // 'R'

    localparam logic [7:0] RespOk      = 8'h4B;  // 'K'
    localparam logic [7:0] RespBadOp   = 8'h3F;  // '?'
    localparam logic [7:0] RespTimeout = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StWdata = 3'd2,
        StBus   = 3'd3,
        StResp  = 3'd4
    } state_e;

endpackage

// File: rtl/iomem_bridge_wdt.sv
// Bus wait watchdog: counts cycles the bridge waits for iomem_ready.
//   CLKOUT    : clock, rising edge
//   resetn    : synchronous active-low reset
//   clear_i   : force the count to zero (held while not in BUS)
//   enable_i  : count this cycle (waiting without ready)
//   limit_i   : count value at which expired_o asserts
//   expired_o : count has reached limit_i
module iomem_bridge_wdt (
    input  logic        CLKOUT,
    input  logic        resetn,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] count_q;

    assign expired_o = (count_q == limit_i);

    // Saturates at the limit so a stalled FSM cannot wrap the counter.
    always_ff @(posedge CLKOUT) begin
        if (!resetn || clear_i) begin
            count_q <= 16'd0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/iomem_bridge_master.sv
// Byte-stream command bridge acting as an iomem bus initiator.
// Commands: 'W' a3 a2 a1 a0 d3 d2 d1 d0 -> 'K'
//           'R' a3 a2 a1 a0             -> r3 r2 r1 r0
// Unknown opcode -> '?', bus wait beyond TIMEOUT_CYCLES -> 'T'.
//   CLKOUT, resetn            : clock, synchronous active-low reset
//   rx_valid/rx_ready/rx_data : command byte input
//   tx_valid/tx_ready/tx_data : response byte output
//   iomem_*                   : initiator side of the SoC iomem bus
module iomem_bridge_master
    import iomem_bridge_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 CLKOUT,
    input  logic                 resetn,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [7:0]           rx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 iomem_valid,
    input  logic                 iomem_ready,
    output logic [3:0]           iomem_wstrb,
    output logic [AddrWidth-1:0] iomem_addr,
    output logic [DataWidth-1:0] iomem_wdata,
    input  logic [DataWidth-1:0] iomem_rdata
);

    localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

    state_e               state_q, state_d;
    logic                 op_write_q, op_write_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0]           last_q, last_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    // Response shift register; tx_data is always its top byte.
    logic [DataWidth-1:0] resp_q, resp_d;
    logic                 valid_q;
    logic                 rx_fire, tx_fire;
    logic                 wdt_expired;

    iomem_bridge_wdt u_wdt (
        .CLKOUT    (CLKOUT),
        .resetn    (resetn),
        .clear_i   (state_q != StBus),
        .enable_i  ((state_q == StBus) && !iomem_ready),
        .limit_i   (TimeoutLimit),
        .expired_o (wdt_expired)
    );

    assign rx_ready    = (state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata);
    assign tx_valid    = (state_q == StResp);
    assign tx_data     = resp_q[DataWidth-1 -: 8];
    assign rx_fire     = rx_valid && rx_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign iomem_valid = valid_q;
    assign iomem_wstrb = wstrb_q;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        wstrb_d    = wstrb_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;

        unique case (state_q)
            StIdle: begin
                if (rx_fire) begin
                    cnt_d = 2'd0;
                    if (rx_data == OpWrite || rx_data == OpRead) begin
                        op_write_d = (rx_data == OpWrite);
                        wstrb_d    = (rx_data == OpWrite) ? 4'hF : 4'h0;
                        state_d    = StAddr;
                    end else begin
                        resp_d  = {RespBadOp, 24'h0};
                        last_d  = 2'd0;
                        state_d = StResp;
                    end
                end
            end
            StAddr: begin
                if (rx_fire) begin
                    addr_d = {addr_q[AddrWidth-9:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = op_write_q ? StWdata : StBus;
                    end
                end
            end
            StWdata: begin
                if (rx_fire) begin
                    wdata_d = {wdata_q[DataWidth-9:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                cnt_d = 2'd0;
                // Ready is checked first so it wins over a coincident timeout.
                if (iomem_ready) begin
                    state_d = StResp;
                    if (op_write_q) begin
                        resp_d = {RespOk, 24'h0};
                        last_d = 2'd0;
                    end else begin
                        resp_d = iomem_rdata;
                        last_d = 2'd3;
                    end
                end else if (wdt_expired) begin
                    state_d = StResp;
                    resp_d  = {RespTimeout, 24'h0};
                    last_d  = 2'd0;
                end
            end
            StResp: begin
                if (tx_fire) begin
                    resp_d = {resp_q[DataWidth-9:0], 8'h00};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == last_q) begin
                        cnt_d   = 2'd0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            state_q    <= StIdle;
            op_write_q <= 1'b0;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            wstrb_q    <= 4'h0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            wstrb_q    <= wstrb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            // Registered strobe: high exactly while the FSM sits in BUS.
            valid_q    <= (state_d == StBus);
        end
    end

endmodule

// File: tb/tb_iomem_bridge_master.sv
module tb_iomem_bridge_master;

    logic        CLKOUT = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    // Results of the most recent bus / response helper.
    int          bus_cycles;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_unstable;
    logic [7:0]  got_byte;

    iomem_bridge_master #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLKOUT      (CLKOUT),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata)
    );

    always #5 CLKOUT = ~CLKOUT;

    task automatic tick();
        @(posedge CLKOUT);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!rx_ready) begin
            $display("FAIL send_byte: rx_ready never high for %02h", b);
            $fatal(1);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    // Plays the responder; ready_delay < 0 means never ready.
    task automatic run_bus(input int ready_delay, input logic [31:0] rdata);
        int guard = 0;
        bus_cycles   = 0;
        bus_unstable = 1'b0;
        while (!iomem_valid && guard < 20) begin
            tick();
            guard++;
        end
        bus_addr  = iomem_addr;
        bus_wdata = iomem_wdata;
        bus_wstrb = iomem_wstrb;
        while (iomem_valid && bus_cycles < 100) begin
            if (iomem_addr !== bus_addr || iomem_wdata !== bus_wdata ||
                iomem_wstrb !== bus_wstrb) bus_unstable = 1'b1;
            iomem_ready = (bus_cycles == ready_delay);
            iomem_rdata = rdata;
            tick();
            iomem_ready = 1'b0;
            bus_cycles++;
        end
    endtask

    // One response handshake; a missing byte is reported as 8'hxx.
    task automatic recv_byte();
        int guard = 0;
        while (!tx_valid && guard < 50) begin
            tick();
            guard++;
        end
        got_byte = tx_valid ? tx_data : 8'hxx;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (iomem_valid !== 1'b0 || tx_valid !== 1'b0 || iomem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b tx_valid=%b wstrb=%h, want 0 0 0",
                     iomem_valid, tx_valid, iomem_wstrb);
        end
        checks++;
        if (iomem_addr !== 32'h0 || iomem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h wdata=%h, want 0 0", iomem_addr, iomem_wdata);
        end
        resetn = 1'b1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rx_ready: got %b want 1", rx_ready);
        end
    endtask

    task automatic test_write();
        logic [7:0] cmd [9];
        cmd = '{8'h57, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD};
        foreach (cmd[i]) send_byte(cmd[i]);
        run_bus(1, 32'h0);
        checks++;
        if (bus_addr !== 32'h03000000) begin
            errors++;
            $display("FAIL write_addr: got %h want 03000000", bus_addr);
        end
        checks++;
        if (bus_wdata !== 32'h0000ABCD) begin
            errors++;
            $display("FAIL write_wdata: got %h want 0000abcd", bus_wdata);
        end
        checks++;
        if (bus_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL write_wstrb: got %h want f", bus_wstrb);
        end
        checks++;
        if (bus_cycles != 2 || bus_unstable) begin
            errors++;
            $display("FAIL write_valid_len: got %0d cycles unstable=%b want 2 0",
                     bus_cycles, bus_unstable);
        end
        recv_byte();
        checks++;
        if (got_byte !== 8'h4B) begin
            errors++;
            $display("FAIL write_resp: got %h want 4b", got_byte);
        end
        checks++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_idle: rx_ready=%b tx_valid=%b want 1 0", rx_ready, tx_valid);
        end
    endtask

    task automatic send_read(input logic [31:0] addr);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    endtask

    task automatic test_read();
        logic [7:0] exp [4];
        exp = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_read(32'h03000000);
        run_bus(0, 32'h12345678);
        checks++;
        if (bus_wstrb !== 4'h0 || bus_addr !== 32'h03000000 || bus_cycles != 1) begin
            errors++;
            $display("FAIL read_bus: wstrb=%h addr=%h cycles=%0d want 0 03000000 1",
                     bus_wstrb, bus_addr, bus_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            recv_byte();
            checks++;
            if (got_byte !== exp[i]) begin
                errors++;
                $display("FAIL read_byte%0d: got %h want %h", i, got_byte, exp[i]);
            end
        end
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_no_extra: tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic saw_valid;
        send_byte(8'h00);
        saw_valid = iomem_valid;
        recv_byte();
        saw_valid = saw_valid | iomem_valid;
        checks++;
        if (got_byte !== 8'h3F || saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL badop_resp: got %h valid_seen=%b want 3f 0", got_byte, saw_valid);
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL badop_rx_ready: got %b want 1", rx_ready);
        end
        send_read(32'hA5A50010);
        run_bus(2, 32'hDEADBEEF);
        checks++;
        if (bus_addr !== 32'hA5A50010 || bus_cycles != 3 || bus_unstable) begin
            errors++;
            $display("FAIL b2b_bus: addr=%h cycles=%0d unstable=%b want a5a50010 3 0",
                     bus_addr, bus_cycles, bus_unstable);
        end
        recv_byte();
        checks++;
        if (got_byte !== 8'hDE) begin
            errors++;
            $display("FAIL b2b_byte0: got %h want de", got_byte);
        end
        for (int i = 0; i < 3; i++) recv_byte();
        checks++;
        if (got_byte !== 8'hEF) begin
            errors++;
            $display("FAIL b2b_byte3: got %h want ef", got_byte);
        end
    endtask

    task automatic test_timeout();
        send_read(32'h00000040);
        run_bus(-1, 32'h0);
        checks++;
        if (bus_cycles != 9) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles want 9", bus_cycles);
        end
        recv_byte();
        checks++;
        if (got_byte !== 8'h54) begin
            errors++;
            $display("FAIL timeout_resp: got %h want 54", got_byte);
        end
        checks++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: rx_ready=%b tx_valid=%b want 1 0", rx_ready, tx_valid);
        end
    endtask

    task automatic test_backpressure();
        logic held_ok = 1'b1;
        send_read(32'h00000100);
        run_bus(0, 32'h12345678);
        for (int i = 0; i < 20; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h12) held_ok = 1'b0;
            tick();
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL stall_hold: tx_valid=%b tx_data=%h want 1 12", tx_valid, tx_data);
        end
        recv_byte();
        checks++;
        if (got_byte !== 8'h12) begin
            errors++;
            $display("FAIL stall_byte0: got %h want 12", got_byte);
        end
        recv_byte();
        checks++;
        if (got_byte !== 8'h34) begin
            errors++;
            $display("FAIL stall_byte1: got %h want 34", got_byte);
        end
        for (int i = 0; i < 2; i++) recv_byte();
    endtask

    task automatic test_reset_mid_bus();
        logic saw_tx = 1'b0;
        send_read(32'h00000200);
        checks++;
        if (iomem_valid !== 1'b1) begin
            errors++;
            $display("FAIL midbus_valid: got %b want 1", iomem_valid);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (iomem_valid !== 1'b0 || tx_valid !== 1'b0 || iomem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midbus_abort: valid=%b tx_valid=%b addr=%h want 0 0 0",
                     iomem_valid, tx_valid, iomem_addr);
        end
        resetn = 1'b1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL midbus_rx_ready: got %b want 1", rx_ready);
        end
        for (int i = 0; i < 5; i++) begin
            saw_tx = saw_tx | tx_valid;
            tick();
        end
        checks++;
        if (saw_tx !== 1'b0) begin
            errors++;
            $display("FAIL midbus_no_resp: tx_valid seen=%b want 0", saw_tx);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
